// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - Moore sequencer driving an 8-bit multiply datapath per command
// Optional accepted-command counter enabled by SEQ_CMD_COUNT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_hi,
  output logic [7:0]  rsp_lo,
  output logic        rsp_err,
  output logic [2:0]  INS,
  output logic        LDAcc,
  output logic        LDMQ,
  output logic        LDDR,
  output logic        STAcc,
  output logic        STMQ,
  output logic        STDR,
  output logic        TESTMODE,
  output logic [7:0]  inBUS,
  input  logic [7:0]  outBUS,
  input  logic        RDY,
  output logic [15:0] cmd_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_DR, S_LD_MQ, S_CLR_ACC, S_EXEC, S_RD_ACC, S_RD_MQ, S_RESP
  } state_t;

  state_t     state;
  logic [7:0] a_q;
  logic [7:0] wait_cnt;
  logic       accept;

  assign STDR     = 1'b0;
  assign TESTMODE = 1'b0;
  assign accept   = (state == S_IDLE) && cmd_valid;

  // Outputs are registered alongside the state so each strobe is high exactly in its state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      a_q       <= 8'h00;
      wait_cnt  <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_hi    <= 8'h00;
      rsp_lo    <= 8'h00;
      rsp_err   <= 1'b0;
      INS       <= 3'b000;
      LDAcc     <= 1'b0;
      LDMQ      <= 1'b0;
      LDDR      <= 1'b0;
      STAcc     <= 1'b0;
      STMQ      <= 1'b0;
      inBUS     <= 8'h00;
    end else begin
      LDAcc <= 1'b0;
      LDMQ  <= 1'b0;
      LDDR  <= 1'b0;
      STAcc <= 1'b0;
      STMQ  <= 1'b0;
      inBUS <= 8'h00;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            a_q       <= cmd_a;
            INS       <= cmd_op;
            cmd_ready <= 1'b0;
            LDDR      <= 1'b1;
            inBUS     <= cmd_b;
            state     <= S_LD_DR;
          end
        end
        S_LD_DR: begin
          LDMQ  <= 1'b1;
          inBUS <= a_q;
          state <= S_LD_MQ;
        end
        S_LD_MQ: begin
          LDAcc <= 1'b1;
          state <= S_CLR_ACC;
        end
        S_CLR_ACC: begin
          wait_cnt <= 8'h00;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (RDY || (wait_cnt == 8'(TIMEOUT - 1))) begin
            rsp_err  <= !RDY;
            wait_cnt <= 8'h00;
            STAcc    <= 1'b1;
            state    <= S_RD_ACC;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RD_ACC: begin
          rsp_hi <= outBUS;
          STMQ   <= 1'b1;
          state  <= S_RD_MQ;
        end
        S_RD_MQ: begin
          rsp_lo    <= outBUS;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            INS       <= 3'b000;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          INS       <= 3'b000;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_CMD_COUNT_EN
  logic [15:0] cmd_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_count_q <= 16'h0000;
    end else if (accept && (cmd_count_q != 16'hFFFF)) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign cmd_count = cmd_count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign cmd_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
// Covers SEQ_CMD_COUNT_EN both defined and undefined.
module tb_alu_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [7:0]  cmd_a = 8'h00;
  logic [7:0]  cmd_b = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_hi;
  logic [7:0]  rsp_lo;
  logic        rsp_err;
  logic [2:0]  INS;
  logic        LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, TESTMODE;
  logic [7:0]  inBUS;
  logic [7:0]  outBUS;
  logic        RDY = 1'b0;
  logic [15:0] cmd_count;

  logic [7:0]  dp_acc = 8'h00;
  logic [7:0]  dp_mq  = 8'h00;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  // Minimal datapath: drives Acc or MQ onto outBUS while the matching store strobe is high.
  assign outBUS = STAcc ? dp_acc : (STMQ ? dp_mq : 8'hEE);

  alu_cmd_sequencer #(.TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
    .INS(INS), .LDAcc(LDAcc), .LDMQ(LDMQ), .LDDR(LDDR),
    .STAcc(STAcc), .STMQ(STMQ), .STDR(STDR), .TESTMODE(TESTMODE),
    .inBUS(inBUS), .outBUS(outBUS), .RDY(RDY), .cmd_count(cmd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    chk("strobe_onehot", 32'($countones({LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR}) <= 1), 32'd1);
    chk("stdr_testmode", {30'd0, STDR, TESTMODE}, 32'd0);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] acc, input logic [7:0] mq);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; dp_acc = acc; dp_mq = mq;
    RDY = 1'b1; rsp_ready = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("run_latency", n, 7);
    chk("run_hi", rsp_hi, acc);
    chk("run_lo", rsp_lo, mq);
    chk("run_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("run_idle_ready", cmd_ready, 1);
  endtask

  initial begin
    int n;
    int acc_cyc[$];
    int seq[$];
    logic saw_valid;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_strobes", {LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR}, 0);
    chk("rst_ins_inbus", {INS, inBUS}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_hi, rsp_lo}, 0);
    chk("rst_cmd_count", cmd_count, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Basic command, accepted on first posedge after reset release
    cmd_op = 3'b100; cmd_a = 8'h05; cmd_b = 8'h03; RDY = 1'b1;
    dp_acc = 8'h00; dp_mq = 8'h0F; cmd_valid = 1'b1;
    chk("t1_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_op = 3'b000;
    chk("t1_lddr", LDDR, 1);
    chk("t1_dr_bus", inBUS, 8'h03);
    chk("t1_ins", INS, 3'b100);
    chk("t1_busy", cmd_ready, 0);
    step();
    chk("t1_ldmq", LDMQ, 1);
    chk("t1_mq_bus", inBUS, 8'h05);
    step();
    chk("t1_ldacc", LDAcc, 1);
    chk("t1_acc_bus", inBUS, 8'h00);
    step();
    chk("t1_exec", {STAcc, rsp_valid, inBUS}, 0);
    chk("t1_exec_ins", INS, 3'b100);
    step();
    chk("t1_stacc", STAcc, 1);
    step();
    chk("t1_stmq", STMQ, 1);
    chk("t1_hi_early", rsp_hi, 8'h00);
    step();
    chk("t1_valid_c7", rsp_valid, 1);
    chk("t1_hi", rsp_hi, 8'h00);
    chk("t1_lo", rsp_lo, 8'h0F);
    chk("t1_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_ready", cmd_ready, 1);
    chk("t1_done_ins", INS, 0);

    // RDY never arrives: timeout, then a 20-cycle stalled response
    cmd_op = 3'b010; cmd_a = 8'hAA; cmd_b = 8'h55; RDY = 1'b0;
    dp_acc = 8'hC3; dp_mq = 8'h3C; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    n = 0;
    while (!STAcc && n < 200) begin
      step();
      n++;
    end
    chk("t2_exec_cycles", n, 64);
    step();
    chk("t2_stmq", STMQ, 1);
    step();
    chk("t2_valid", rsp_valid, 1);
    chk("t2_err", rsp_err, 1);
    chk("t2_hi", rsp_hi, 8'hC3);
    chk("t2_lo", rsp_lo, 8'h3C);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t2_hold", {cmd_ready, rsp_valid, rsp_err, rsp_hi, rsp_lo}, {1'b0, 1'b1, 1'b1, 8'hC3, 8'h3C});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t2_release_valid", rsp_valid, 0);
    chk("t2_release_ready", cmd_ready, 1);

    // Reset during EXEC discards the command
    cmd_op = 3'b111; cmd_a = 8'h12; cmd_b = 8'h34; RDY = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    chk("t3_exec_ins", INS, 3'b111);
    reset_n = 1'b0;
    #1;
    chk("t3_rst_ins", INS, 0);
    chk("t3_rst_strobes", {LDAcc, LDMQ, LDDR, STAcc, STMQ, inBUS}, 0);
    chk("t3_rst_idle", {cmd_ready, rsp_valid}, {1'b1, 1'b0});
    @(posedge clock);
    #1 reset_n = 1'b1;
    RDY = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("t3_no_rsp", saw_valid, 0);
    run_cmd(3'b001, 8'h11, 8'h22, 8'h5A, 8'hA5);

    // Back-to-back commands with cmd_valid held high
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    cmd_op = 3'b011; cmd_a = 8'h21; cmd_b = 8'h43; RDY = 1'b1; rsp_ready = 1'b1;
    dp_acc = 8'h01; dp_mq = 8'h02; cmd_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (cmd_ready) acc_cyc.push_back(i);
      if (LDDR)  seq.push_back(1);
      if (LDMQ)  seq.push_back(2);
      if (LDAcc) seq.push_back(3);
      if (STAcc) seq.push_back(4);
      if (STMQ)  seq.push_back(5);
      step();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("t4_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("t4_gap1", acc_cyc[1] - acc_cyc[0], 8);
      chk("t4_gap2", acc_cyc[2] - acc_cyc[1], 8);
    end
    chk("t4_seq_len", seq.size(), 15);
    for (int k = 0; k < seq.size(); k++) chk("t4_seq", seq[k], (k % 5) + 1);

`ifdef SEQ_CMD_COUNT_EN
    chk("t5_count3", cmd_count, 16'd3);
    force dut.cmd_count_q = 16'hFFFE;
    #1 release dut.cmd_count_q;
    run_cmd(3'b101, 8'h09, 8'h07, 8'h10, 8'h20);
    chk("t5_count_sat1", cmd_count, 16'hFFFF);
    run_cmd(3'b110, 8'h08, 8'h06, 8'h30, 8'h40);
    chk("t5_count_sat2", cmd_count, 16'hFFFF);
`else
    chk("t5_count_off", cmd_count, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
